hardwired_control_unit: RTL

//  Hardwired instruction sequencer that drives the datapath control strobes; it replaces bench-driven T-state stimulus.

---
 rtl/hardwired_control_unit.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/hardwired_control_unit.sv
// Hardwired fetch/execute sequencer: walks T0..T6 and drives the datapath strobes and one-hot ALU op.
// Build option CU_MEM_WAIT_EN: T1 is held until mem_ready is sampled high (default build: T1 is one cycle).
module hardwired_control_unit #(
    parameter bit RESET_TO_HALT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        stop,
    input  logic        go,
    input  logic        mem_ready,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [12:0] alu_op,
    output logic        running,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_RESET,
        S_HALT,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6
    } state_e;

    typedef enum logic [1:0] {
        C_ALU3,
        C_MULDIV,
        C_UNARY,
        C_ILLEGAL
    } op_class_e;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int unsigned A_AND  = 0;
    localparam int unsigned A_OR   = 1;
    localparam int unsigned A_ADD  = 2;
    localparam int unsigned A_SUB  = 3;
    localparam int unsigned A_MUL  = 4;
    localparam int unsigned A_DIV  = 5;
    localparam int unsigned A_SHR  = 6;
    localparam int unsigned A_SHRA = 7;
    localparam int unsigned A_SHL  = 8;
    localparam int unsigned A_ROR  = 9;
    localparam int unsigned A_ROL  = 10;
    localparam int unsigned A_NEG  = 11;
    localparam int unsigned A_NOT  = 12;

    state_e      state_q, state_d;
    logic        running_q, running_d;
    logic        illegal_q, illegal_d;

    op_class_e   op_class;
    logic [12:0] alu_onehot;
    logic [4:0]  opcode;
    logic [15:0] sel_ra, sel_rb, sel_rc;
    state_e      last_next;

    assign opcode = ir[31:27];
    assign sel_ra = 16'd1 << ir[26:23];
    assign sel_rb = 16'd1 << ir[22:19];
    assign sel_rc = 16'd1 << ir[18:15];

    // Low IR bits carry immediates for other instruction formats; this unit never looks at them.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[14:0];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
        op_class   = C_ILLEGAL;
        alu_onehot = '0;
        case (opcode)
            OP_ADD:  begin op_class = C_ALU3;   alu_onehot[A_ADD]  = 1'b1; end
            OP_SUB:  begin op_class = C_ALU3;   alu_onehot[A_SUB]  = 1'b1; end
            OP_SHR:  begin op_class = C_ALU3;   alu_onehot[A_SHR]  = 1'b1; end
            OP_SHRA: begin op_class = C_ALU3;   alu_onehot[A_SHRA] = 1'b1; end
            OP_SHL:  begin op_class = C_ALU3;   alu_onehot[A_SHL]  = 1'b1; end
            OP_ROR:  begin op_class = C_ALU3;   alu_onehot[A_ROR]  = 1'b1; end
            OP_ROL:  begin op_class = C_ALU3;   alu_onehot[A_ROL]  = 1'b1; end
            OP_AND:  begin op_class = C_ALU3;   alu_onehot[A_AND]  = 1'b1; end
            OP_OR:   begin op_class = C_ALU3;   alu_onehot[A_OR]   = 1'b1; end
            OP_DIV:  begin op_class = C_MULDIV; alu_onehot[A_DIV]  = 1'b1; end
            OP_MUL:  begin op_class = C_MULDIV; alu_onehot[A_MUL]  = 1'b1; end
            OP_NEG:  begin op_class = C_UNARY;  alu_onehot[A_NEG]  = 1'b1; end
            OP_NOT:  begin op_class = C_UNARY;  alu_onehot[A_NOT]  = 1'b1; end
            default: ;
        endcase
    end

    // The final T-state of every instruction samples stop to choose between the next fetch and HALT.
    assign last_next = stop ? S_HALT : S_T0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = RESET_TO_HALT ? S_HALT : S_T0;
            S_HALT:  if (go && !stop && !illegal_q) state_d = S_T0;
            S_T0:    state_d = S_T1;
`ifdef CU_MEM_WAIT_EN
            S_T1:    if (mem_ready) state_d = S_T2;
`else
            S_T1:    state_d = S_T2;
`endif
            S_T2:    state_d = S_T3;
            S_T3:    state_d = (op_class == C_ILLEGAL) ? S_HALT : S_T4;
            S_T4:    state_d = (op_class == C_UNARY) ? last_next : S_T5;
            S_T5:    state_d = (op_class == C_ALU3) ? last_next : S_T6;
            S_T6:    state_d = last_next;
            default: state_d = S_RESET;
        endcase
    end

`ifndef CU_MEM_WAIT_EN
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
`endif

    assign running_d = (state_d != S_RESET) && (state_d != S_HALT);
    assign illegal_d = illegal_q || ((state_q == S_T3) && (op_class == C_ILLEGAL));

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!reset) begin
            state_q   <= S_RESET;
            running_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            illegal_q <= illegal_d;
        end
    end

    assign running = running_q;
    assign illegal = illegal_q;

    // Strobes are decoded from state_q and the live IR rather than pre-registered: IR is loaded on the
    // same edge that enters T3, so its fields are not known one cycle early.
    always_comb begin
        Rout     = '0;
        Rin      = '0;
        alu_op   = '0;
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        Read     = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                PCin  = 1'b1;
            end
            S_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                case (op_class)
                    C_ALU3:   begin Rout = sel_rb; Yin = 1'b1; end
                    C_MULDIV: begin Rout = sel_ra; Yin = 1'b1; end
                    C_UNARY:  begin Rout = sel_rb; alu_op = alu_onehot; Zin = 1'b1; end
                    default:  ;
                endcase
            end
            S_T4: begin
                case (op_class)
                    C_ALU3:   begin Rout = sel_rc; alu_op = alu_onehot; Zin = 1'b1; end
                    C_MULDIV: begin Rout = sel_rb; alu_op = alu_onehot; Zin = 1'b1; end
                    C_UNARY:  begin Zlowout = 1'b1; Rin = sel_ra; end
                    default:  ;
                endcase
            end
            S_T5: begin
                case (op_class)
                    C_ALU3:   begin Zlowout = 1'b1; Rin = sel_ra; end
                    C_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
                    default:  ;
                endcase
            end
            S_T6: begin
                if (op_class == C_MULDIV) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
